// File: rtl/mnist_pkg.sv
// Shared types for the MNIST feature pipeline: feature word and the
// stream-side state encoding used by both source and sink blocks.
package mnist_pkg;

  typedef logic signed [15:0] feature_type;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } stream_state_t;

endpackage

// File: rtl/feature_stream_source_if.sv
// Valid/ready feature stream between a feature source and a consumer.
interface feature_stream_source_if;
  import mnist_pkg::*;

  feature_type feature_out;
  logic        feature_out_valid;
  logic        feature_out_ready;

  modport master (
    output feature_out,
    output feature_out_valid,
    input  feature_out_ready
  );

  modport slave (
    input  feature_out,
    input  feature_out_valid,
    output feature_out_ready
  );

endinterface

// File: rtl/feature_buffer_ram.sv
// Plane buffer: one synchronous write port, one read port with a
// single cycle of latency. Read data holds while rd_en is low.
module feature_buffer_ram
  import mnist_pkg::*;
#(
  parameter int DEPTH = 200,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  feature_type   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output feature_type   rd_data
);

  feature_type mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/feature_stream_source.sv
// Buffers NUM_IMAGES feature planes and replays them in raster order
// over a valid/ready stream on each start request.
//
//   state  | meaning
//   IDLE   | buffer writable, waiting for start
//   PRIME  | read of address 0 issued
//   STREAM | issuing reads as the output stage and skid have room
//   FLUSH  | all reads issued, draining remaining beats
module feature_stream_source
  import mnist_pkg::*;
#(
  parameter  int IMAGE_HEIGHT = 10,
  parameter  int IMAGE_WIDTH  = 10,
  parameter  int NUM_IMAGES   = 2,
  localparam int DEPTH        = NUM_IMAGES * IMAGE_HEIGHT * IMAGE_WIDTH,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           wr_en,
  input  logic [AW-1:0]                  wr_addr,
  input  feature_type                    wr_data,
  output logic                           wr_err,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  feature_stream_source_if.master        fs
);

  stream_state_t state;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] beat_cnt;
  logic          ram_v;
  logic          skid_v;
  feature_type   skid_d;
  feature_type   ram_rdata;
  logic          out_valid;
  logic          wr_ok;
  logic          hs;
  logic          skid_left;
  logic          ram_left;
  logic          room;
  logic          rd_en;
  logic          last_read;
  logic          last_beat;

  feature_buffer_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clock   (clock),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_rdata)
  );

  assign busy  = (state != IDLE);
  assign wr_ok = wr_en && (state == IDLE) && ({1'b0, wr_addr} < (AW+1)'(DEPTH));

  // The RAM read register is the output stage; the skid always holds the older beat.
  assign out_valid             = skid_v | ram_v;
  assign fs.feature_out_valid  = out_valid;
  assign fs.feature_out        = skid_v ? skid_d : (ram_v ? ram_rdata : '0);

  assign hs        = out_valid & fs.feature_out_ready;
  assign skid_left = skid_v & ~hs;
  assign ram_left  = ram_v & ~(hs & ~skid_v);
  assign room      = ~(skid_left & ram_left);
  assign rd_en     = ((state == PRIME) || (state == STREAM)) && room;
  assign last_read = (rd_addr == AW'(DEPTH - 1));
  assign last_beat = hs && (beat_cnt == AW'(DEPTH - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      rd_addr  <= '0;
      beat_cnt <= '0;
      ram_v    <= 1'b0;
      skid_v   <= 1'b0;
      skid_d   <= '0;
      done     <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      done   <= 1'b0;
      wr_err <= wr_en & ~wr_ok;

      if (hs) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;

      ram_v <= rd_en | ram_left;
      if (rd_en && ram_left) begin
        skid_v <= 1'b1;
        skid_d <= ram_rdata;
      end else if (skid_v && hs) begin
        skid_v <= 1'b0;
      end

      if (rd_en && !last_read) rd_addr <= rd_addr + 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            state   <= PRIME;
            rd_addr <= '0;
          end
        end
        PRIME:  state <= last_read ? FLUSH : STREAM;
        STREAM: if (rd_en && last_read) state <= FLUSH;
        FLUSH: begin
          if (last_beat) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_feature_stream_source.sv
// Randomised bench for feature_stream_source against a queue-based
// model of the buffer contents and the frame-level stream behaviour.
module tb_feature_stream_source;
  import mnist_pkg::*;

  localparam int H     = 10;
  localparam int W     = 10;
  localparam int N     = 2;
  localparam int DEPTH = N * H * W;
  localparam int AW    = $clog2(DEPTH);

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_en   = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  feature_type   wr_data = '0;
  logic          start   = 1'b0;
  logic          wr_err;
  logic          busy;
  logic          done;

  feature_stream_source_if fs_if ();

  feature_stream_source #(
    .IMAGE_HEIGHT (H),
    .IMAGE_WIDTH  (W),
    .NUM_IMAGES   (N)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_err  (wr_err),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .fs      (fs_if)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // model state
  feature_type m_mem [DEPTH];
  feature_type exp_q [$];
  feature_type obs [DEPTH];
  feature_type prev_data;
  bit m_busy = 0, m_done = 0, m_wr_err = 0, checking = 0;
  bit prev_stall = 0, got_first = 0, v, r, last;
  int frame_cnt = 0, n_done = 0, n_wr_err = 0, total_beats = 0, cyc = 0;
  int start_cyc = 0, first_valid_cyc = 0, done_cyc = 0;
  int ready_mode = 0;

  // Compare process: outputs of this cycle first, then advance the model.
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (checking) begin
        v = fs_if.feature_out_valid;
        r = fs_if.feature_out_ready;
        check("busy", int'(busy), int'(m_busy));
        check("done", int'(done), int'(m_done));
        check("wr_err", int'(wr_err), int'(m_wr_err));
        if (done) begin n_done++; done_cyc = cyc; end
        if (wr_err) n_wr_err++;
        if (prev_stall) begin
          check("held_valid", int'(v), 1);
          check("held_data", int'(fs_if.feature_out), int'(prev_data));
        end
        if (v) begin
          if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
          else check("beat_data", int'(fs_if.feature_out), int'(exp_q[0]));
          if (!got_first) begin got_first = 1; first_valid_cyc = cyc; end
        end
        prev_stall = reset_n && v && !r;
        prev_data  = fs_if.feature_out;

        if (!reset_n) begin
          exp_q.delete();
          m_busy = 0; m_done = 0; m_wr_err = 0; frame_cnt = 0;
          prev_stall = 0;
        end else begin
          last = 0;
          if (v && r && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            obs[frame_cnt] = fs_if.feature_out;
            frame_cnt++;
            total_beats++;
            if (frame_cnt == DEPTH) last = 1;
          end
          m_done   = last;
          m_wr_err = wr_en && (m_busy || int'(wr_addr) >= DEPTH);
          if (wr_en && !m_wr_err) m_mem[wr_addr] = wr_data;
          if (m_busy) m_busy = !last;
          else if (start) begin
            m_busy = 1;
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) exp_q.push_back(m_mem[i]);
            frame_cnt = 0;
            start_cyc = cyc;
            got_first = 0;
          end
        end
      end
    end
  end

  initial begin
    fs_if.feature_out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      fs_if.feature_out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_word(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = feature_type'(d);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic load_pattern(input bit rnd);
    for (int i = 0; i < DEPTH; i++)
      write_word(i, rnd ? int'($urandom_range(0, 65535)) : (i % (H * W)));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_dones(input int target, input int budget, input string name);
    int b;
    b = budget;
    while (n_done < target && b > 0) begin tick(); b--; end
    check(name, n_done, target);
  endtask

  task automatic wait_beats(input int target, input int budget, input string name);
    int b;
    b = budget;
    while (frame_cnt < target && b > 0) begin tick(); b--; end
    check(name, int'(frame_cnt >= target), 1);
  endtask

  int b0, e0, d1, b;

  initial begin
    tick();
    tick();
    checking = 1;
    reset_n  = 1'b1;
    tick();
    check("rst_valid", int'(fs_if.feature_out_valid), 0);
    check("rst_data", int'(fs_if.feature_out), 0);
    check("rst_busy", int'(busy), 0);

    // full rate, incrementing load
    load_pattern(0);
    b0 = total_beats;
    pulse_start();
    wait_dones(1, 400, "t1_done");
    check("t1_first_valid_lat", first_valid_cyc - start_cyc, 2);
    check("t1_done_lat", done_cyc - start_cyc, 202);
    check("t1_beats", total_beats - b0, 200);
    check("t1_obs0", int'(obs[0]), 0);
    check("t1_obs57", int'(obs[57]), 57);
    check("t1_obs100", int'(obs[100]), 0);
    check("t1_obs199", int'(obs[199]), 99);
    tick();
    check("t1_busy_after", int'(busy), 0);

    // random backpressure
    ready_mode = 1;
    b0 = total_beats;
    pulse_start();
    wait_dones(2, 3000, "t2_done");
    check("t2_beats", total_beats - b0, 200);
    ready_mode = 0;
    tick();

    // illegal writes
    e0 = n_wr_err;
    write_word(200, 1234);
    pulse_start();
    repeat (5) tick();
    write_word(5, 999);
    wait_dones(3, 400, "t3_done");
    check("t3_wr_err_count", n_wr_err - e0, 2);
    pulse_start();
    wait_dones(4, 400, "t3_replay_done");
    check("t3_replay_addr5", int'(obs[5]), 5);
    check("t3_replay_addr199", int'(obs[199]), 99);

    // start while busy
    b0 = total_beats;
    pulse_start();
    wait_beats(50, 400, "t4_reach50");
    pulse_start();
    wait_dones(5, 400, "t4_done");
    repeat (10) tick();
    check("t4_single_done", n_done, 5);
    check("t4_beats", total_beats - b0, 200);
    check("t4_idle", int'(busy), 0);

    // reset mid-frame
    pulse_start();
    wait_beats(73, 400, "t5_reach73");
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("t5_valid_after_reset", int'(fs_if.feature_out_valid), 0);
    check("t5_busy_after_reset", int'(busy), 0);
    repeat (5) tick();
    check("t5_no_done", n_done, 5);
    pulse_start();
    wait_dones(6, 400, "t5_done");
    check("t5_obs0", int'(obs[0]), 0);
    check("t5_obs73", int'(obs[73]), 73);

    // back-to-back frames
    b0 = total_beats;
    pulse_start();
    b = 400;
    while (!done && b > 0) begin tick(); b--; end
    check("t6_first_done_seen", int'(done), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    d1 = done_cyc;
    wait_dones(8, 400, "t6_done");
    check("t6_frame_gap", done_cyc - d1, 202);
    check("t6_first_valid_lat", first_valid_cyc - start_cyc, 2);
    check("t6_beats", total_beats - b0, 400);

    // random data with random backpressure
    tick();
    load_pattern(1);
    ready_mode = 1;
    pulse_start();
    wait_dones(9, 3000, "t7_done");
    ready_mode = 0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/feature_stream_source.md
Name: feature_stream_source

Overview:
- Transmit end of the feature valid/ready stream consumed by convolution (features_in side).
- Holds NUM_IMAGES planes of IMAGE_HEIGHT x IMAGE_WIDTH features in a local buffer, loaded through a simple write port.
- On start, replays the planes in raster order: plane-major, then row, then column.
- Replaces the behavioural driver loop in benches and sits between the MNIST loader and the first convolution layer.

Parameters:
- IMAGE_HEIGHT, 10, rows per plane.
- IMAGE_WIDTH, 10, columns per plane.
- NUM_IMAGES, 2, planes per frame.
- DEPTH, NUM_IMAGES*IMAGE_HEIGHT*IMAGE_WIDTH (localparam), buffer entries.
- AW, $clog2(DEPTH) (localparam), address width.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  AW  linear write address, plane*H*W + r*W + c.
- wr_data  in  $bits(feature_type)  feature to store.
- wr_err  out  1  one-cycle pulse: write rejected (busy or addr >= DEPTH).
- start  in  1  one-cycle request to stream one frame.
- busy  out  1  high from accepted start until last handshake.
- done  out  1  one-cycle pulse in the cycle after the last handshake.
- feature_out  out  $bits(feature_type)  streamed feature.
- feature_out_valid  out  1  feature_out holds a valid beat.
- feature_out_ready  in  1  downstream accepts the beat.

Behaviour:
- Reset: synchronous. At a clock edge with reset_n=0, all of the following are 0: state=IDLE, busy, done, wr_err, feature_out_valid, feature_out, read counters, skid entry. Buffer contents are not cleared.
- Reset mid-stream: valid drops at that edge, the frame is abandoned, and no done pulse is issued.
- Buffer: single-port-read, single-port-write synchronous RAM (DEPTH x feature_type). Read data is available one cycle after the address is issued.
- Writes are accepted only in IDLE with wr_addr < DEPTH. Otherwise the buffer is unchanged and wr_err pulses in the next cycle.
- FSM states: IDLE, PRIME, STREAM, FLUSH.
  - IDLE: start=1 -> PRIME; rd_addr=0; busy=1 next cycle.
  - PRIME: issue read of address 0 -> STREAM.
  - STREAM: issue reads while rd_addr < DEPTH and the output stage plus skid has room after this cycle's handshake. After the last read issues -> FLUSH.
  - FLUSH: drain the remaining beats. The last handshake (valid & ready) -> IDLE. busy=0 and done=1 for exactly the next cycle.
- start outside IDLE is ignored: no restart and no error.
- start in the same cycle as done is accepted.
- Latency: with ready held high, first valid appears 2 cycles after the start cycle. One beat per cycle follows, no bubbles. done follows DEPTH+2 cycles after start.
- Handshake rules:
  - A beat transfers on a rising edge with valid & ready.
  - While valid=1 and ready=0, feature_out is held stable and valid stays 1.
  - valid never depends combinationally on ready.
  - ready may toggle freely. There is no combinational path from ready to any output.
- Backpressure: the read issued in the cycle ready falls lands in a 1-entry skid register. No beat is dropped or duplicated, and order is preserved exactly.
- Counters: the read address counts 0..DEPTH-1 and then stops; it never wraps. A separate beat counter counts handshakes 0..DEPTH-1 and determines the last beat.
- Data: feature_out carries buffer contents verbatim. No arithmetic and no sign or width change.

Decomposition:
- mnist_pkg: feature_type (already present).
- Add to mnist_pkg a stream_state_t enum {IDLE, PRIME, STREAM, FLUSH}, so the sink-side block can share it.
- One sub-module: feature_buffer_ram, the parameterised synchronous RAM (write port plus 1-cycle read port).
- Output register and skid stay in the top.

Test Plan:
- Incrementing load, full rate: write value = r*10+c to both planes; pulse start; hold ready=1.
  -> first valid at start+2; 200 beats 0..99, 0..99 in order; done at start+202; busy low after done.
- Random backpressure: same load; ready driven by 50% random.
  -> identical 200-beat sequence; feature_out stable whenever valid & !ready; exactly one done.
- Illegal writes: wr_en during busy and wr_en with wr_addr=200.
  -> wr_err pulses once each; buffer unchanged, checked by a later replay.
- Start while busy: second start at beat 50.
  -> ignored; exactly 200 beats and one done.
- Reset mid-frame: reset_n=0 for 1 cycle at beat 73, then a fresh start.
  -> valid=0 the edge after reset; no done for the aborted frame; new frame begins at value 0 (buffer retained).
- Back-to-back frames: start asserted in the done cycle.
  -> second frame's first valid 2 cycles later; 400 beats total; no gaps beyond the 2-cycle prime.
